// File: rtl/encoder_pkg.sv
// ============================================================================
// encoder_pkg : shared types and the priority-search helper for prio_encoder_pipe
// Revision    : 1.0
// ============================================================================
`default_nettype none

package encoder_pkg;

  typedef enum logic {ENC_MSB_FIRST, ENC_LSB_FIRST} enc_mode_e;
  typedef enum logic {DIR_DOWN, DIR_UP} prio_dir_e;

  // Widest vector the search helper handles; IN_W must not exceed this.
  localparam int PRIO_MAX_W = 64;
  localparam int PRIO_IDX_W = 6;

  typedef struct packed {
    logic                  found;
    logic [PRIO_IDX_W-1:0] idx;
  } prio_res_t;

  // Walks from 'start' in direction 'dir', wrapping modulo (mask+1); first set bit wins.
  function automatic prio_res_t prio_find(input logic [PRIO_MAX_W-1:0] vec,
                                          input logic [PRIO_IDX_W-1:0] start,
                                          input prio_dir_e             dir,
                                          input logic [PRIO_IDX_W-1:0] mask);
    prio_res_t             res;
    logic [PRIO_IDX_W-1:0] pos;
    res = '0;
    for (int k = 0; k < PRIO_MAX_W; k++) begin
      if (dir == DIR_UP) pos = (start + PRIO_IDX_W'(k)) & mask;
      else               pos = (start - PRIO_IDX_W'(k)) & mask;
      if (!res.found && vec[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_out_fifo.sv
// ============================================================================
// enc_out_fifo : 2-entry synchronous FIFO with registered push_ready
// Revision     : 1.0
// ============================================================================
`default_nettype none

module enc_out_fifo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         ready_q;
  logic         do_push;
  logic         do_pop;

  assign do_push    = push_valid && ready_q;
  assign do_pop     = pop_valid && pop_ready;
  assign pop_valid  = (count != 2'd0);
  assign push_ready = ready_q;
  assign pop_data   = head_q;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 2'd1;
    else if (!do_push && do_pop) count_nxt = count - 2'd1;
  end

  // ready is registered from the next count so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= 2'd0;
      ready_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt < 2'd2);
      if (do_pop)
        head_q <= do_push ? push_data : tail_q;
      else if (do_push && count == 2'd0)
        head_q <= push_data;
      if (do_push && !do_pop && count == 2'd1)
        tail_q <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prio_encoder_pipe.sv
// ============================================================================
// prio_encoder_pipe : registered N-to-log2(N) priority encoder with 2-entry output buffer
// Optional macro PRIO_ENCODER_RR_EN selects round-robin priority instead of MODE.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module prio_encoder_pipe
  import encoder_pkg::*;
#(
  parameter int        IN_W  = 4,
  parameter enc_mode_e MODE  = ENC_MSB_FIRST,
  localparam int       OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             out_any,
  output logic             out_multi
);

  localparam logic [PRIO_IDX_W-1:0] IDX_MASK = PRIO_IDX_W'(IN_W - 1);
  localparam int                    ENTRY_W  = OUT_W + 2;

  logic [PRIO_MAX_W-1:0] vec_ext;
  logic [PRIO_IDX_W-1:0] search_start;
  prio_dir_e             search_dir;
  prio_res_t             winner;
  logic                  unused_win;
  logic [OUT_W-1:0]      enc_idx;
  logic                  enc_any;
  logic                  enc_multi;
  logic                  push;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;

  assign vec_ext = PRIO_MAX_W'(data_in);
  assign push    = in_valid && in_ready;

`ifdef PRIO_ENCODER_RR_EN
  logic [OUT_W-1:0] rr_ptr;

  assign search_start = PRIO_IDX_W'(rr_ptr);
  assign search_dir   = DIR_UP;

  // IN_W is a power of two, so the OUT_W-bit add wraps exactly at IN_W.
  always_ff @(posedge clk) begin
    if (!reset)
      rr_ptr <= '0;
    else if (push && enc_any)
      rr_ptr <= enc_idx + OUT_W'(1);
  end
`else
  assign search_start = (MODE == ENC_MSB_FIRST) ? IDX_MASK : '0;
  assign search_dir   = (MODE == ENC_MSB_FIRST) ? DIR_DOWN : DIR_UP;
`endif

  assign winner     = prio_find(vec_ext, search_start, search_dir, IDX_MASK);
  assign unused_win = ^winner.idx;
  assign enc_idx    = winner.idx[OUT_W-1:0];
  assign enc_any    = winner.found;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign enc_multi  = |(data_in & (data_in - IN_W'(1)));

  assign push_entry = {enc_idx, enc_any, enc_multi};

  enc_out_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_entry)
  );

  assign {data_out, out_any, out_multi} = head_entry;

endmodule

`default_nettype wire
